ldpc_vpu_sched: RTL and testbench
=================================

Name: ldpc_vpu_sched

Overview:
- Iteration scheduler for the 4x24 LDPC decoder.
- Sequences the variable-node processing unit (VPU) across all 24 columns of a codeword, then hands off to the check-node phase.
- Repeats until MAX_ITER iterations complete, or until the syndrome passes (optional feature).
- Sits between the top-level decoder control and the LLR/message memories; drives memory read/write strobes, VPU enable and column addresses.

Parameters:
- COL_NUM, 24, columns per codeword (VPU passes per iteration).
- MAX_ITER, 8, maximum decoding iterations (1..255).
- RD_LAT, 1, memory read latency in cycles (rd_en to data valid at VPU inputs).
- VPU_LAT, 1, VPU latency in cycles (en to registered llr_out valid).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin decoding a codeword; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when decoding ends.
- iter_cnt  out  8  completed iterations; final value valid at done.
- rd_en  out  1  read strobe to intrinsic and check-message memories.
- rd_addr  out  5  column address for rd_en.
- vpu_en  out  1  VPU enable (en).
- wr_en  out  1  write strobe for VPU outputs (llr_out_0..3, llr_all).
- wr_addr  out  5  column address for wr_en.
- cnu_start  out  1  one-cycle pulse starting the check-node phase.
- cnu_done  in  1  one-cycle pulse: check-node phase finished.
- syndrome_ok  in  1  sampled with cnu_done; all parity checks satisfied.

Behaviour:
- Reset (asynchronous, rst_n low) puts the FSM in IDLE and clears every output and internal counter to 0, including the address pipeline. Reset mid-operation abandons the codeword; no done pulse.
- States: IDLE, VNU, DRAIN, CNU, DONE.
- IDLE: start=1 moves to VNU, clears iter_cnt and sets col=0. start in any other state is ignored.
- VNU: rd_en=1 with rd_addr=col for COL_NUM consecutive cycles (col 0..23). After col=23 go to DRAIN. No bubbles.
- Pipeline timing, with rd_en for column c at cycle t:
  - vpu_en=1 at t+RD_LAT.
  - wr_en=1 with wr_addr=c at t+RD_LAT+VPU_LAT.
  - Implemented as a delay line of {valid, addr}; wr_addr is the delayed rd_addr, never recomputed.
- DRAIN: wait until the delay line is empty (last wr_en issued). In the same cycle pulse cnu_start and go to CNU. With defaults, the first rd_en is at cycle 0, the last wr_en at cycle 25 and cnu_start at cycle 26.
- CNU: wait for cnu_done. On cnu_done, iter_cnt increments (saturating at 255). Then:
  - iter_cnt+1 == MAX_ITER → DONE.
  - otherwise → VNU with col=0.
- cnu_done outside CNU is ignored.
- DONE: done=1 for one cycle, busy drops in the same cycle, next state IDLE. A start in the DONE cycle is ignored; start is accepted from IDLE only.
- busy=1 in VNU, DRAIN and CNU.
- rd_en and wr_en may be high in the same cycle for different columns; the memories are dual-port.
- The column counter wraps 23→0 only through the iteration loop; rd_addr never exceeds COL_NUM-1.

Optional Feature:
- Macro LDPC_SCHED_EARLY_STOP_EN.
- Defined: on cnu_done with syndrome_ok=1, increment iter_cnt and go to DONE regardless of the iteration count. The early-stop check takes priority over the MAX_ITER check.
- Not defined: syndrome_ok is ignored and exactly MAX_ITER iterations always run.

Decomposition:
- Shared package ldpc_pkg: COL_NUM, COL_WEIGHT, LLR_WIDTH, ADDR_WIDTH=$clog2(COL_NUM), and the sched_state_t enum {IDLE, VNU, DRAIN, CNU, DONE}.
- One natural sub-module: ldpc_addr_pipe, a parameterised-depth shift register of {valid, addr}. It is instanced once for the RD_LAT tap (vpu_en) and once with depth RD_LAT+VPU_LAT (wr_en/wr_addr).

Test Plan:
- Reset mid-VNU (rst_n low at rd_addr=10) → all outputs 0 immediately; FSM in IDLE after release; no done pulse; the next start decodes normally.
- Single iteration, MAX_ITER=1, cnu_done 5 cycles after cnu_start:
  - rd_en high 24 cycles, addr 0..23.
  - vpu_en high cycles 1..24.
  - wr_en high cycles 2..25 with wr_addr = rd_addr delayed 2.
  - cnu_start at cycle 26, done at cycle 32, iter_cnt=1.
- MAX_ITER=8, syndrome_ok=0 → exactly 8 VNU sweeps (192 rd_en pulses) and 8 cnu_start pulses; iter_cnt=8 at done.
- Early stop (macro defined), syndrome_ok=1 on the 3rd cnu_done → done follows, iter_cnt=3. Same stimulus with the macro undefined → iter_cnt=8.
- start pulses while busy, and in the DONE cycle → ignored: no restart, iter_cnt unaffected. Stray cnu_done during VNU → no effect on the sweep.
- RD_LAT=2, VPU_LAT=3 → wr_en lags rd_en by exactly 5 cycles for every column; cnu_start only after wr_addr=23 has been written.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants, FSM state type and helpers for the 4x24 LDPC decoder.
package ldpc_pkg;

  localparam int COL_NUM    = 24;
  localparam int COL_WEIGHT = 4;
  localparam int LLR_WIDTH  = 6;
  localparam int ADDR_WIDTH = $clog2(COL_NUM);
  localparam int ITER_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VNU   = 3'd1,
    DRAIN = 3'd2,
    CNU   = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // Iteration counter increment that sticks at the top value instead of wrapping.
  function automatic logic [ITER_WIDTH-1:0] iter_inc(input logic [ITER_WIDTH-1:0] v);
    return (v == {ITER_WIDTH{1'b1}}) ? v : v + ITER_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ldpc_addr_pipe.sv
// Fixed-depth shift register of {valid, column address}; o_pending reports
// whether any valid entry will still be in flight after the next edge.
module ldpc_addr_pipe #(
  parameter int DEPTH = 1,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_pending
);

  logic [DEPTH:0] w_vchain;
  logic [AW-1:0]  w_achain [DEPTH+1];

  assign w_vchain[0] = i_valid;
  assign w_achain[0] = i_addr;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          r_valid;
      logic [AW-1:0] r_addr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_addr  <= '0;
        end else begin
          r_valid <= w_vchain[gi];
          r_addr  <= w_achain[gi];
        end
      end

      assign w_vchain[gi+1] = r_valid;
      assign w_achain[gi+1] = r_addr;
    end
  endgenerate

  assign o_valid   = w_vchain[DEPTH];
  assign o_addr    = w_achain[DEPTH];
  // The output stage is being consumed this cycle, so it does not count.
  assign o_pending = |w_vchain[DEPTH-1:0];

endmodule

// File: rtl/ldpc_vpu_sched.sv
// LDPC iteration scheduler: sweeps the VPU over all columns, drains the
// read/VPU pipeline, runs the check-node phase, repeats up to MAX_ITER times.
// Optional early stop on syndrome_ok: define LDPC_SCHED_EARLY_STOP_EN.
module ldpc_vpu_sched #(
  parameter int COL_NUM  = 24,
  parameter int MAX_ITER = 8,
  parameter int RD_LAT   = 1,
  parameter int VPU_LAT  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [7:0]                     iter_cnt,
  output logic                           rd_en,
  output logic [ldpc_pkg::ADDR_WIDTH-1:0] rd_addr,
  output logic                           vpu_en,
  output logic                           wr_en,
  output logic [ldpc_pkg::ADDR_WIDTH-1:0] wr_addr,
  output logic                           cnu_start,
  input  logic                           cnu_done,
  input  logic                           syndrome_ok
);

  import ldpc_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(COL_NUM - 1);

  sched_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [7:0]            r_iter;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_en;
  logic                  r_cnu_start;

  logic                  w_vpu_valid;
  logic [ADDR_WIDTH-1:0] w_vpu_addr;
  logic                  w_vpu_pending;
  logic                  w_wr_valid;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_wr_pending;
  logic                  w_last_iter;
  logic                  w_stop;

  assign w_last_iter = ({1'b0, r_iter} + 9'd1) == 9'(MAX_ITER);

`ifdef LDPC_SCHED_EARLY_STOP_EN
  assign w_stop = syndrome_ok | w_last_iter;
`else
  logic w_unused_synd;
  assign w_unused_synd = syndrome_ok;
  assign w_stop        = w_last_iter;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_iter      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_cnu_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_cnu_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= VNU;
            r_col   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
          end
        end
        VNU: begin
          if (r_col == LAST_COL) begin
            r_state <= DRAIN;
            r_col   <= '0;
            r_rd_en <= 1'b0;
          end else begin
            r_col <= r_col + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // The write tap is the longest path; once it empties, every column is written.
          if (!w_wr_pending) begin
            r_state     <= CNU;
            r_cnu_start <= 1'b1;
          end
        end
        CNU: begin
          if (cnu_done) begin
            r_iter <= iter_inc(r_iter);
            if (w_stop) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= VNU;
              r_col   <= '0;
              r_rd_en <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  ldpc_addr_pipe #(
    .DEPTH (RD_LAT),
    .AW    (ADDR_WIDTH)
  ) u_vpu_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (r_rd_en),
    .i_addr    (r_col),
    .o_valid   (w_vpu_valid),
    .o_addr    (w_vpu_addr),
    .o_pending (w_vpu_pending)
  );

  ldpc_addr_pipe #(
    .DEPTH (RD_LAT + VPU_LAT),
    .AW    (ADDR_WIDTH)
  ) u_wr_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (r_rd_en),
    .i_addr    (r_col),
    .o_valid   (w_wr_valid),
    .o_addr    (w_wr_addr),
    .o_pending (w_wr_pending)
  );

  logic w_unused_vpu;
  assign w_unused_vpu = ^{w_vpu_addr, w_vpu_pending};

  assign busy      = r_busy;
  assign done      = r_done;
  assign iter_cnt  = r_iter;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_col;
  assign vpu_en    = w_vpu_valid;
  assign wr_en     = w_wr_valid;
  assign wr_addr   = w_wr_addr;
  assign cnu_start = r_cnu_start;

endmodule

// File: tb/tb_ldpc_vpu_sched.sv
// Bench for ldpc_vpu_sched: three configurations run side by side against a
// closed-form timeline model (period = columns + pipeline + check-node wait).
module tb_ldpc_vpu_sched;

  localparam int NCFG = 3;
  localparam int NCOL = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic       cnu_done_w [NCFG];
  logic       synd_w     [NCFG];
  logic       busy_w     [NCFG];
  logic       done_w     [NCFG];
  logic [7:0] iter_w     [NCFG];
  logic       rd_en_w    [NCFG];
  logic [4:0] rd_addr_w  [NCFG];
  logic       vpu_en_w   [NCFG];
  logic       wr_en_w    [NCFG];
  logic [4:0] wr_addr_w  [NCFG];
  logic       cs_w       [NCFG];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cfg0: single iteration; cfg1: 8 iterations with syndrome_ok on the 3rd
  // check-node pass; cfg2: long pipeline (RD_LAT=2, VPU_LAT=3).
  function automatic int cfg_max(int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 2;
  endfunction
  function automatic int cfg_rd(int k);
    return (k == 2) ? 2 : 1;
  endfunction
  function automatic int cfg_vpu(int k);
    return (k == 2) ? 3 : 1;
  endfunction
  function automatic int cfg_n(int k);
    return (k == 0) ? 5 : (k == 1) ? 3 : 4;
  endfunction
  function automatic int cfg_es(int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic int k_iter(int k);
`ifdef LDPC_SCHED_EARLY_STOP_EN
    if (cfg_es(k) != 0 && cfg_es(k) < cfg_max(k)) return cfg_es(k);
`endif
    return cfg_max(k);
  endfunction
  function automatic int period(int k);
    return NCOL + cfg_rd(k) + cfg_vpu(k) + cfg_n(k) + 1;
  endfunction

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      ldpc_vpu_sched #(
        .COL_NUM  (NCOL),
        .MAX_ITER (cfg_max(gi)),
        .RD_LAT   (cfg_rd(gi)),
        .VPU_LAT  (cfg_vpu(gi))
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy_w[gi]),
        .done        (done_w[gi]),
        .iter_cnt    (iter_w[gi]),
        .rd_en       (rd_en_w[gi]),
        .rd_addr     (rd_addr_w[gi]),
        .vpu_en      (vpu_en_w[gi]),
        .wr_en       (wr_en_w[gi]),
        .wr_addr     (wr_addr_w[gi]),
        .cnu_start   (cs_w[gi]),
        .cnu_done    (cnu_done_w[gi]),
        .syndrome_ok (synd_w[gi])
      );
    end
  endgenerate

  // Model: act = a codeword is in progress, rel = cycles since the first VNU cycle.
  bit act  [NCFG];
  int rel  [NCFG];
  int hold [NCFG];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NCFG; k++) begin
      if (!rst_n) begin
        act[k]  <= 1'b0;
        rel[k]  <= 0;
        hold[k] <= 0;
      end else if (!act[k]) begin
        if (start) begin
          act[k] <= 1'b1;
          rel[k] <= 0;
        end
      end else if (rel[k] == k_iter(k) * period(k)) begin
        act[k]  <= 1'b0;
        hold[k] <= k_iter(k);
      end else begin
        rel[k] <= rel[k] + 1;
      end
    end
  end

  // Check-node responder, timed from the model rather than from the DUT.
  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      int dp, di, dph, dl2;
      dp  = period(k);
      dl2 = cfg_rd(k) + cfg_vpu(k);
      cnu_done_w[k] = 1'b0;
      synd_w[k]     = 1'b0;
      if (act[k] && rel[k] < k_iter(k) * dp) begin
        di  = rel[k] / dp;
        dph = rel[k] % dp;
        if (dph == NCOL + dl2 + cfg_n(k)) begin
          cnu_done_w[k] = 1'b1;
          synd_w[k]     = (cfg_es(k) != 0) && (di == cfg_es(k) - 1);
        end
        if (k == 2 && di == 0 && dph == 5) cnu_done_w[k] = 1'b1;
      end
    end
  end

  int rd_cnt   [NCFG];
  int cs_cnt   [NCFG];
  int done_cnt [NCFG];
  int sweep_t  [NCFG];
  int cs_t     [NCFG];
  int done_t   [NCFG];
  int rd_t     [NCFG][32];

  bit e_busy, e_done, e_rd, e_vpu, e_wr, e_cs, ok;
  int e_iter, e_rda, e_wra, mp, mk, ml1, ml2, mi, mph;

  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      mp  = period(k);
      mk  = k_iter(k);
      ml1 = cfg_rd(k);
      ml2 = ml1 + cfg_vpu(k);
      e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_vpu = 1'b0; e_wr = 1'b0; e_cs = 1'b0;
      e_rda  = 0; e_wra = 0; e_iter = hold[k];
      if (act[k]) begin
        if (rel[k] < mk * mp) begin
          mi     = rel[k] / mp;
          mph    = rel[k] % mp;
          e_busy = 1'b1;
          e_iter = mi;
          e_rd   = mph < NCOL;
          e_rda  = mph;
          e_vpu  = (mph >= ml1) && (mph < ml1 + NCOL);
          e_wr   = (mph >= ml2) && (mph < ml2 + NCOL);
          e_wra  = mph - ml2;
          e_cs   = mph == NCOL + ml2;
        end else begin
          e_done = 1'b1;
          e_iter = mk;
        end
      end
      ok = (busy_w[k] == e_busy) && (done_w[k] == e_done) && (rd_en_w[k] == e_rd) &&
           (vpu_en_w[k] == e_vpu) && (wr_en_w[k] == e_wr) && (cs_w[k] == e_cs) &&
           (int'(iter_w[k]) == e_iter) &&
           (!e_rd || int'(rd_addr_w[k]) == e_rda) && (!e_wr || int'(wr_addr_w[k]) == e_wra);
      n_tests++;
      if (!ok) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL cycle cfg%0d cyc=%0d: got busy=%b done=%b rd=%b/%0d vpu=%b wr=%b/%0d cs=%b it=%0d, want busy=%b done=%b rd=%b/%0d vpu=%b wr=%b/%0d cs=%b it=%0d",
                   k, cyc, busy_w[k], done_w[k], rd_en_w[k], rd_addr_w[k], vpu_en_w[k], wr_en_w[k],
                   wr_addr_w[k], cs_w[k], iter_w[k], e_busy, e_done, e_rd, e_rda, e_vpu, e_wr,
                   e_wra, e_cs, e_iter);
      end
      if (rd_en_w[k]) begin
        rd_cnt[k]++;
        rd_t[k][rd_addr_w[k]] = cyc;
        if (rd_addr_w[k] == 5'd0) sweep_t[k] = cyc;
      end
      if (cs_w[k]) begin
        cs_cnt[k]++;
        cs_t[k] = cyc;
      end
      if (done_w[k]) begin
        done_cnt[k]++;
        done_t[k] = cyc;
      end
      if (k == 2 && wr_en_w[k]) begin
        n_tests++;
        if (cyc - rd_t[2][wr_addr_w[2]] != 5) begin
          n_fail++;
          $display("FAIL wr_lag col %0d: got %0d cycles, want 5", wr_addr_w[2], cyc - rd_t[2][wr_addr_w[2]]);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
    $display("[TB] check %s: got %0d want %0d", name, got, want);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int b_rd [NCFG];
  int b_cs [NCFG];
  int b_dn [NCFG];
  bit any_act;
  bit hit;

  initial begin
    for (int k = 0; k < NCFG; k++) begin
      cnu_done_w[k] = 1'b0;
      synd_w[k]     = 1'b0;
      rd_cnt[k] = 0; cs_cnt[k] = 0; done_cnt[k] = 0;
      sweep_t[k] = 0; cs_t[k] = 0; done_t[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy_w[0], done_w[0], rd_en_w[0], vpu_en_w[0], wr_en_w[0], cs_w[0]}), 0);
    chk("reset_iter_addr", int'({iter_w[0], rd_addr_w[0], wr_addr_w[0]}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abandon a codeword with an asynchronous reset in the middle of the sweep.
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      hit = rd_en_w[0] && (rd_addr_w[0] == 5'd10);
    end
    chk("reach_col10", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++)
      chk($sformatf("async_reset_cfg%0d", k),
          int'({busy_w[k], done_w[k], rd_en_w[k], vpu_en_w[k], wr_en_w[k], cs_w[k], iter_w[k], rd_addr_w[k], wr_addr_w[k]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NCFG; k++) b_dn[k] = done_cnt[k];
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", done_cnt[0] - b_dn[0] + done_cnt[1] - b_dn[1] + done_cnt[2] - b_dn[2], 0);

    // Full decode, with stray start pulses mid-sweep and in cfg0's DONE cycle.
    for (int k = 0; k < NCFG; k++) begin
      b_rd[k] = rd_cnt[k];
      b_cs[k] = cs_cnt[k];
      b_dn[k] = done_cnt[k];
    end
    pulse_start();
    any_act = 1'b1;
    for (int c = 0; c < 2000 && any_act; c++) begin
      @(negedge clk);
      start   = act[0] && (rel[0] == 15 || rel[0] == 32);
      any_act = act[0] || act[1] || act[2];
    end
    start = 1'b0;
    chk("run_terminates", int'(any_act), 0);
    repeat (3) @(negedge clk);

    chk("cfg0_rd_pulses", rd_cnt[0] - b_rd[0], 24);
    chk("cfg0_cnu_start_cycle", cs_t[0] - sweep_t[0], 26);
    chk("cfg0_done_cycle", done_t[0] - sweep_t[0], 32);
    chk("cfg0_iter_cnt", int'(iter_w[0]), 1);
    chk("cfg0_done_pulses", done_cnt[0] - b_dn[0], 1);
`ifdef LDPC_SCHED_EARLY_STOP_EN
    chk("cfg1_rd_pulses", rd_cnt[1] - b_rd[1], 72);
    chk("cfg1_cnu_starts", cs_cnt[1] - b_cs[1], 3);
    chk("cfg1_iter_cnt", int'(iter_w[1]), 3);
`else
    chk("cfg1_rd_pulses", rd_cnt[1] - b_rd[1], 192);
    chk("cfg1_cnu_starts", cs_cnt[1] - b_cs[1], 8);
    chk("cfg1_iter_cnt", int'(iter_w[1]), 8);
`endif
    chk("cfg1_done_pulses", done_cnt[1] - b_dn[1], 1);
    chk("cfg2_rd_pulses", rd_cnt[2] - b_rd[2], 48);
    chk("cfg2_cnu_start_after_sweep", cs_t[2] - sweep_t[2], 29);
    chk("cfg2_iter_cnt", int'(iter_w[2]), 2);
    chk("idle_busy", int'({busy_w[0], busy_w[1], busy_w[2]}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
